retire_queue: RTL and testbench
===============================

RETIRE_QUEUE -- requirements
Module: retire_queue

Interface
REQ-001 Parameter NR_ENTRIES, default 8, queue depth; power of two, minimum 4.
REQ-002 Parameter NR_WB_PORTS, default 2, number of writeback ports.
REQ-003 Parameter NR_COMMIT_PORTS, default 2, entries presented to the commit stage.
REQ-004 Ports: one clock; reset is asynchronous and active-high.
REQ-005 clk_i  in  1  clock; all state updates on the rising edge.
REQ-006 rst_i  in  1  asynchronous active-high reset.
REQ-007 flush_i  in  1  discard all entries.
REQ-008 issue_valid_i  in  1  allocation request.
REQ-009 issue_instr_i  in  scoreboard_entry_t  decoded instruction: pc, rd, fu, op, bp, ex.
REQ-010 issue_ready_o  out  1  entry available.
REQ-011 issue_trans_id_o  out  TRANS_ID_BITS  index to be allocated.
REQ-012 wb_valid_i  in  NR_WB_PORTS  writeback strobes.
REQ-013 wb_trans_id_i  in  NR_WB_PORTS x TRANS_ID_BITS  target entries.
REQ-014 wb_result_i  in  NR_WB_PORTS x XLEN  results.
REQ-015 wb_ex_i  in  NR_WB_PORTS x exception_t  execution exceptions.
REQ-016 commit_instr_o  out  NR_COMMIT_PORTS x scoreboard_entry_t  oldest entries; .valid means ready to retire.
REQ-017 commit_ack_i  in  NR_COMMIT_PORTS  retire strobes from the commit stage.
REQ-018 empty_o  out  1  no allocated entries.

Function
REQ-019 State: per-entry issued bit, done bit and scoreboard_entry_t payload; commit_ptr and issue_ptr of log2(NR_ENTRIES) bits; count of log2(NR_ENTRIES)+1 bits.
REQ-020 Both pointers wrap modulo NR_ENTRIES; an increment from NR_ENTRIES-1 yields 0.
REQ-021 issue_ready_o = (count < NR_ENTRIES) and !flush_i, computed from registered count only; a same-cycle retire does not free a slot for issue.
REQ-022 issue_trans_id_o = issue_ptr, combinational.
REQ-023 Allocation occurs on issue_valid_i and issue_ready_o:
- payload <= issue_instr_i, with trans_id = issue_ptr
- issued <= 1
- done <= issue_instr_i.ex.valid, so a fetch or decode exception retires without writeback
- issue_ptr advances by 1.
REQ-024 Writeback on port k with wb_valid_i[k] to an entry whose issued bit is 1:
- result <= wb_result_i[k]
- done <= 1
- if wb_ex_i[k].valid and the entry holds no exception, ex <= wb_ex_i[k]
- a writeback to an entry whose issued bit is 0 is ignored.
REQ-025 Two writeback ports targeting the same entry in one cycle: the higher port index wins.
REQ-026 An entry allocated in cycle N is not writable in cycle N; the earliest writeback is cycle N+1.
REQ-027 commit_instr_o[i] = payload at commit_ptr+i; valid = issued and done and (i < count); result is zero-latency from registers.
REQ-028 Retire:
- commit_ack_i[0] retires the entry at commit_ptr
- commit_ack_i[1] is honoured only together with commit_ack_i[0] and retires commit_ptr+1
- an ack on an entry presented with valid 0 is ignored
- retired entries clear their issued and done bits; commit_ptr advances by the number retired.
REQ-029 count_next = count + allocated - retired; simultaneous issue and retire is legal, and count never exceeds NR_ENTRIES or underflows.
REQ-030 empty_o = (count == 0).
REQ-031 On flush_i, next cycle:
- all issued and done bits are 0
- both pointers and count are 0
- same-cycle issue, writeback and ack are ignored.
REQ-032 Latency: allocation in cycle N with writeback in cycle N+1 yields commit_instr_o[0].valid in cycle N+2 at the earliest.

Reset
REQ-033 On rst_i, asynchronously: pointers, count, and all issued and done bits are 0; payloads are 0.
REQ-034 While in reset and after reset: issue_ready_o=1 (unless flush_i), empty_o=1, all commit_instr_o valid bits 0.
REQ-035 Reset asserted mid-operation discards all entries without emitting any commit valid.

Verification
REQ-036 Issue A, writeback A in the next cycle -> commit_instr_o[0].valid=1 two cycles after issue, with result and trans_id 0.
REQ-037 Issue 8 entries with no writebacks -> issue_ready_o=0 and count=8; ack attempts ignored; write back entry 0 and ack it -> issue_ready_o=1 the cycle after.
REQ-038 Write back entry 1 before entry 0 -> no commit valid; then write back entry 0 -> both ports valid; ack 2'b11 -> commit_ptr=2.
REQ-039 Run 20 issue/retire pairs -> pointers wrap 7->0, trans_ids repeat modulo 8, count stays at most 8.
REQ-040 Issue an entry with ex.valid=1 -> port 0 valid the next cycle with no writeback; assert flush_i while 5 entries are pending -> empty_o=1 the next cycle, and a late writeback to trans_id 3 is ignored.
REQ-041 Assert rst_i with 4 entries pending -> outputs return to reset values immediately, with no clock edge required.

Source files
------------

// File: rtl/retire_queue.sv
// Purpose : in-order retire queue; allocates entries at issue, collects writebacks, presents oldest entries to commit.
// Latency : issue in cycle N, writeback in N+1, commit_instr_o[0].valid in N+2 at the earliest; outputs are zero-latency from registers.
// Backpr. : issue_ready_o drops when all entries are allocated (registered count only) or during flush; commit_ack_i drains entries.

package retire_queue_pkg;

  localparam int unsigned XLEN          = 32;
  // Wide enough for queues of up to 16 entries; smaller queues zero-extend their index.
  localparam int unsigned TRANS_ID_BITS = 4;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
  } exception_t;

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] target;
  } bp_t;

  typedef struct packed {
    logic [XLEN-1:0]          pc;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [3:0]               fu;
    logic [6:0]               op;
    logic [4:0]               rd;
    logic [XLEN-1:0]          result;
    logic                     valid;
    bp_t                      bp;
    exception_t               ex;
  } scoreboard_entry_t;

endpackage

module retire_queue
  import retire_queue_pkg::*;
#(
  parameter int unsigned NR_ENTRIES      = 8,
  parameter int unsigned NR_WB_PORTS     = 2,
  parameter int unsigned NR_COMMIT_PORTS = 2
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      flush_i,
  input  logic                                      issue_valid_i,
  input  scoreboard_entry_t                         issue_instr_i,
  output logic                                      issue_ready_o,
  output logic [TRANS_ID_BITS-1:0]                  issue_trans_id_o,
  input  logic [NR_WB_PORTS-1:0]                    wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] wb_trans_id_i,
  input  logic [NR_WB_PORTS-1:0][XLEN-1:0]          wb_result_i,
  input  exception_t [NR_WB_PORTS-1:0]              wb_ex_i,
  output scoreboard_entry_t [NR_COMMIT_PORTS-1:0]   commit_instr_o,
  input  logic [NR_COMMIT_PORTS-1:0]                commit_ack_i,
  output logic                                      empty_o
);

  localparam int unsigned PTR_W = $clog2(NR_ENTRIES);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Entry storage and occupancy bookkeeping.
  scoreboard_entry_t     r_mem [NR_ENTRIES];
  logic [NR_ENTRIES-1:0] r_issued;
  logic [NR_ENTRIES-1:0] r_done;
  logic [PTR_W-1:0]      r_issue_ptr;
  logic [PTR_W-1:0]      r_commit_ptr;
  logic [CNT_W-1:0]      r_count;

  logic                       w_alloc;
  scoreboard_entry_t          w_alloc_entry;
  logic [PTR_W-1:0]           w_wb_idx [NR_WB_PORTS];
  logic [NR_WB_PORTS-1:0]     w_wb_hit;
  logic [PTR_W-1:0]           w_commit_idx [NR_COMMIT_PORTS];
  logic [NR_COMMIT_PORTS-1:0] w_commit_vld;
  logic [NR_COMMIT_PORTS-1:0] w_retire;
  logic [CNT_W-1:0]           w_num_retired;

  // Readiness depends only on the registered count, so a retire in the same cycle never frees a slot for issue.
  assign issue_ready_o    = (r_count < CNT_W'(NR_ENTRIES)) && !flush_i;
  assign issue_trans_id_o = TRANS_ID_BITS'(r_issue_ptr);
  assign empty_o          = (r_count == '0);
  assign w_alloc          = issue_valid_i && issue_ready_o;

  // Allocation payload: the decoded instruction tagged with the slot it lands in.
  always_comb begin
    w_alloc_entry          = issue_instr_i;
    w_alloc_entry.trans_id = TRANS_ID_BITS'(r_issue_ptr);
    w_alloc_entry.valid    = 1'b0;
  end

  // Writeback decode: only in-range ids that hit an already issued entry take effect.
  always_comb begin
    for (int k = 0; k < NR_WB_PORTS; k++) begin
      w_wb_idx[k] = wb_trans_id_i[k][PTR_W-1:0];
      w_wb_hit[k] = wb_valid_i[k]
                    && (int'(wb_trans_id_i[k]) < NR_ENTRIES)
                    && r_issued[w_wb_idx[k]];
    end
  end

  // Commit window: port i shows the entry at commit_ptr+i, valid once issued, done and inside the occupied range.
  always_comb begin
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      w_commit_idx[i]         = r_commit_ptr + PTR_W'(i);
      w_commit_vld[i]         = r_issued[w_commit_idx[i]]
                                && r_done[w_commit_idx[i]]
                                && (CNT_W'(i) < r_count);
      commit_instr_o[i]       = r_mem[w_commit_idx[i]];
      commit_instr_o[i].valid = w_commit_vld[i];
    end
  end

  // Retire selection: acks are honoured in order and stop at the first missing ack or not-yet-valid entry.
  always_comb begin : retire_sel
    logic run;
    run           = 1'b1;
    w_retire      = '0;
    w_num_retired = '0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      run           = run && commit_ack_i[i] && w_commit_vld[i];
      w_retire[i]   = run;
      w_num_retired = w_num_retired + CNT_W'(run);
    end
  end

  // Pointer and count update; flush wins over every same-cycle request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_issue_ptr  <= '0;
      r_commit_ptr <= '0;
      r_count      <= '0;
    end else if (flush_i) begin
      r_issue_ptr  <= '0;
      r_commit_ptr <= '0;
      r_count      <= '0;
    end else begin
      if (w_alloc) begin
        r_issue_ptr <= r_issue_ptr + PTR_W'(1);
      end
      r_commit_ptr <= r_commit_ptr + w_num_retired[PTR_W-1:0];
      r_count      <= r_count + CNT_W'(w_alloc) - w_num_retired;
    end
  end

  // Entry update: writebacks first (higher port overrides), then retire clears, then the new allocation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_issued <= '0;
      r_done   <= '0;
      for (int e = 0; e < NR_ENTRIES; e++) begin
        r_mem[e] <= '0;
      end
    end else if (flush_i) begin
      r_issued <= '0;
      r_done   <= '0;
    end else begin
      for (int k = 0; k < NR_WB_PORTS; k++) begin
        if (w_wb_hit[k]) begin
          r_mem[w_wb_idx[k]].result <= wb_result_i[k];
          r_done[w_wb_idx[k]]       <= 1'b1;
          // The first recorded exception is kept; later ones do not overwrite it.
          if (wb_ex_i[k].valid && !r_mem[w_wb_idx[k]].ex.valid) begin
            r_mem[w_wb_idx[k]].ex <= wb_ex_i[k];
          end
        end
      end
      for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
        if (w_retire[i]) begin
          r_issued[w_commit_idx[i]] <= 1'b0;
          r_done[w_commit_idx[i]]   <= 1'b0;
        end
      end
      // The allocated slot is always free, so it never collides with a retiring entry.
      if (w_alloc) begin
        r_mem[r_issue_ptr]    <= w_alloc_entry;
        r_issued[r_issue_ptr] <= 1'b1;
        // Instructions that already carry a fetch/decode exception need no writeback.
        r_done[r_issue_ptr]   <= issue_instr_i.ex.valid;
      end
    end
  end

endmodule

// File: tb/tb_retire_queue.sv
// Purpose : self-checking bench for retire_queue: directed vector table, corner sequences, random run against a queue model.
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled 1 unit later.
// Backpr. : model predicts issue_ready_o from occupancy and flush; acks drawn at random.

module tb_retire_queue;
  import retire_queue_pkg::*;

  localparam int NE = 8;
  localparam int NW = 2;
  localparam int NC = 2;

  logic                               clk_i = 1'b0;
  logic                               rst_i;
  logic                               flush_i;
  logic                               issue_valid_i;
  scoreboard_entry_t                  issue_instr_i;
  logic                               issue_ready_o;
  logic [TRANS_ID_BITS-1:0]           issue_trans_id_o;
  logic [NW-1:0]                      wb_valid_i;
  logic [NW-1:0][TRANS_ID_BITS-1:0]   wb_trans_id_i;
  logic [NW-1:0][XLEN-1:0]            wb_result_i;
  exception_t [NW-1:0]                wb_ex_i;
  scoreboard_entry_t [NC-1:0]         commit_instr_o;
  logic [NC-1:0]                      commit_ack_i;
  logic                               empty_o;

  retire_queue #(
    .NR_ENTRIES      (NE),
    .NR_WB_PORTS     (NW),
    .NR_COMMIT_PORTS (NC)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .flush_i          (flush_i),
    .issue_valid_i    (issue_valid_i),
    .issue_instr_i    (issue_instr_i),
    .issue_ready_o    (issue_ready_o),
    .issue_trans_id_o (issue_trans_id_o),
    .wb_valid_i       (wb_valid_i),
    .wb_trans_id_i    (wb_trans_id_i),
    .wb_result_i      (wb_result_i),
    .wb_ex_i          (wb_ex_i),
    .commit_instr_o   (commit_instr_o),
    .commit_ack_i     (commit_ack_i),
    .empty_o          (empty_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    issue_valid_i = 1'b0;
    issue_instr_i = '0;
    wb_valid_i    = '0;
    wb_trans_id_i = '0;
    wb_result_i   = '0;
    wb_ex_i       = '0;
    commit_ack_i  = '0;
    flush_i       = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1'b1;
    #2;
    chk("rst.ready", issue_ready_o, 1);
    chk("rst.empty", empty_o, 1);
    chk("rst.v0", commit_instr_o[0].valid, 0);
    chk("rst.v1", commit_instr_o[1].valid, 0);
    flush_i = 1'b1;
    #1;
    chk("rst.ready_flush", issue_ready_o, 0);
    flush_i = 1'b0;
    rst_i   = 1'b0;
    tick();
  endtask

  // Directed vector records: inputs applied for one cycle, outputs expected while they are applied.
  typedef struct {
    logic       iv;
    logic       exv;
    logic       wbv;
    logic [3:0] wbid;
    logic [1:0] ack;
    logic       fl;
    logic       rdy;
    logic       emp;
    logic       v0;
    logic       v1;
    logic [3:0] tid;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic iv, exv, wbv, input logic [3:0] wbid, input logic [1:0] ack,
                     input logic fl, rdy, emp, v0, v1, input logic [3:0] tid);
    vec_t v;
    v.iv = iv; v.exv = exv; v.wbv = wbv; v.wbid = wbid; v.ack = ack; v.fl = fl;
    v.rdy = rdy; v.emp = emp; v.v0 = v0; v.v1 = v1; v.tid = tid;
    vq.push_back(v);
  endtask

  // Reference model: the queue of allocated instructions, oldest first.
  typedef struct {
    logic [3:0]  tid;
    logic        done;
    logic [31:0] result;
    logic [31:0] pc;
    logic        exv;
    logic [31:0] cause;
  } m_t;

  m_t mq[$];
  int m_next;

  initial begin : main
    int   sz;
    int   n;
    logic ev [NC];
    logic ox [NE];
    m_t   tmp;

    //         iv exv wbv id ack fl | rdy emp v0 v1 tid
    add(0, 0, 0, 0, 2'b00, 0,  1, 1, 0, 0, 0);
    add(1, 0, 0, 0, 2'b00, 0,  1, 1, 0, 0, 0);
    add(0, 0, 1, 0, 2'b00, 0,  1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 2'b01, 0,  1, 0, 1, 0, 1);
    add(1, 0, 0, 0, 2'b00, 0,  1, 1, 0, 0, 1);
    add(1, 0, 0, 0, 2'b00, 0,  1, 0, 0, 0, 2);
    add(0, 0, 1, 2, 2'b00, 0,  1, 0, 0, 0, 3);
    add(0, 0, 1, 1, 2'b10, 0,  1, 0, 0, 1, 3);
    add(0, 0, 0, 0, 2'b11, 0,  1, 0, 1, 1, 3);
    add(1, 1, 0, 0, 2'b00, 0,  1, 1, 0, 0, 3);
    add(0, 0, 0, 0, 2'b00, 0,  1, 0, 1, 0, 4);
    add(0, 0, 0, 0, 2'b10, 0,  1, 0, 1, 0, 4);
    add(0, 0, 0, 0, 2'b01, 0,  1, 0, 1, 0, 4);
    add(1, 0, 1, 4, 2'b00, 0,  1, 1, 0, 0, 4);
    add(0, 0, 0, 0, 2'b00, 0,  1, 0, 0, 0, 5);
    add(0, 0, 1, 4, 2'b00, 0,  1, 0, 0, 0, 5);
    add(0, 0, 0, 0, 2'b11, 0,  1, 0, 1, 0, 5);
    add(1, 0, 0, 0, 2'b00, 1,  0, 1, 0, 0, 5);
    add(1, 0, 0, 0, 2'b00, 0,  1, 1, 0, 0, 0);
    add(0, 0, 1, 0, 2'b00, 0,  1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 2'b01, 1,  0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 2'b00, 0,  1, 1, 0, 0, 0);

    do_reset();

    // Directed table.
    for (int r = 0; r < vq.size(); r++) begin
      idle();
      issue_valid_i          = vq[r].iv;
      issue_instr_i.pc       = 32'h1000 + 32'(r * 4);
      issue_instr_i.ex.valid = vq[r].exv;
      wb_valid_i[0]          = vq[r].wbv;
      wb_trans_id_i[0]       = vq[r].wbid;
      wb_result_i[0]         = 32'hA000 + 32'(r);
      commit_ack_i           = vq[r].ack;
      flush_i                = vq[r].fl;
      #1;
      chk($sformatf("vec%0d.ready", r), issue_ready_o, vq[r].rdy);
      chk($sformatf("vec%0d.empty", r), empty_o, vq[r].emp);
      chk($sformatf("vec%0d.v0", r), commit_instr_o[0].valid, vq[r].v0);
      chk($sformatf("vec%0d.v1", r), commit_instr_o[1].valid, vq[r].v1);
      chk($sformatf("vec%0d.tid", r), issue_trans_id_o, vq[r].tid);
      if (r == 3) begin
        chk("vec3.result", commit_instr_o[0].result, 32'hA002);
        chk("vec3.trans_id", commit_instr_o[0].trans_id, 0);
      end
      tick();
    end

    // Full queue: acks on not-ready entries are ignored, a same-cycle retire does not free a slot.
    do_reset();
    for (int i = 0; i < NE; i++) begin
      idle();
      issue_valid_i    = 1'b1;
      issue_instr_i.pc = 32'h2000 + 32'(i);
      #1;
      chk($sformatf("full.tid%0d", i), issue_trans_id_o, i);
      tick();
    end
    idle();
    #1;
    chk("full.ready", issue_ready_o, 0);
    chk("full.empty", empty_o, 0);
    chk("full.tid_wrap", issue_trans_id_o, 0);
    commit_ack_i = 2'b11;
    tick();
    idle();
    #1;
    chk("full.ack_ignored", issue_ready_o, 0);
    chk("full.v0_nowb", commit_instr_o[0].valid, 0);
    wb_valid_i[0]    = 1'b1;
    wb_trans_id_i[0] = 0;
    wb_result_i[0]   = 32'h5555;
    tick();
    idle();
    commit_ack_i  = 2'b01;
    issue_valid_i = 1'b1;
    #1;
    chk("full.v0_ready", commit_instr_o[0].valid, 1);
    chk("full.ready_same_cycle", issue_ready_o, 0);
    tick();
    idle();
    #1;
    chk("full.ready_after", issue_ready_o, 1);
    chk("full.tid_after", issue_trans_id_o, 0);
    chk("full.v0_next", commit_instr_o[0].valid, 0);

    // Flush with 5 pending, then a late writeback to a discarded entry.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle();
      issue_valid_i = 1'b1;
      tick();
    end
    idle();
    flush_i       = 1'b1;
    issue_valid_i = 1'b1;
    #1;
    chk("flush.ready", issue_ready_o, 0);
    tick();
    idle();
    #1;
    chk("flush.empty", empty_o, 1);
    chk("flush.tid", issue_trans_id_o, 0);
    wb_valid_i[0]    = 1'b1;
    wb_trans_id_i[0] = 3;
    tick();
    idle();
    #1;
    chk("flush.late_wb_empty", empty_o, 1);
    chk("flush.late_wb_v0", commit_instr_o[0].valid, 0);

    // Asynchronous reset mid-operation, observed before the next clock edge.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle();
      issue_valid_i = 1'b1;
      tick();
    end
    idle();
    wb_valid_i[0]    = 1'b1;
    wb_trans_id_i[0] = 0;
    tick();
    idle();
    #1;
    chk("arst.pre_v0", commit_instr_o[0].valid, 1);
    rst_i = 1'b1;
    #1;
    chk("arst.empty", empty_o, 1);
    chk("arst.ready", issue_ready_o, 1);
    chk("arst.v0", commit_instr_o[0].valid, 0);
    chk("arst.tid", issue_trans_id_o, 0);
    rst_i = 1'b0;
    tick();

    // Two writeback ports hitting one entry: the higher port's result wins.
    do_reset();
    idle();
    issue_valid_i = 1'b1;
    tick();
    idle();
    wb_valid_i       = 2'b11;
    wb_trans_id_i[0] = 0;
    wb_trans_id_i[1] = 0;
    wb_result_i[0]   = 32'h111;
    wb_result_i[1]   = 32'h222;
    tick();
    idle();
    #1;
    chk("wbpri.v0", commit_instr_o[0].valid, 1);
    chk("wbpri.result", commit_instr_o[0].result, 32'h222);

    // Random traffic against the queue model.
    do_reset();
    mq.delete();
    m_next = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      idle();
      issue_valid_i             = ($urandom_range(0, 9) < 6);
      issue_instr_i.pc          = $urandom;
      issue_instr_i.result      = $urandom;
      issue_instr_i.rd          = 5'($urandom);
      issue_instr_i.ex.valid    = ($urandom_range(0, 15) == 0);
      issue_instr_i.ex.cause    = $urandom;
      for (int k = 0; k < NW; k++) begin
        wb_valid_i[k]  = $urandom_range(0, 1);
        if (mq.size() > 0 && $urandom_range(0, 4) != 0)
          wb_trans_id_i[k] = mq[$urandom_range(0, mq.size() - 1)].tid;
        else
          wb_trans_id_i[k] = 4'($urandom_range(0, NE - 1));
        wb_result_i[k]    = $urandom;
        wb_ex_i[k].valid  = ($urandom_range(0, 7) == 0);
        wb_ex_i[k].cause  = $urandom;
        wb_ex_i[k].tval   = $urandom;
      end
      commit_ack_i[0] = ($urandom_range(0, 9) < 6);
      commit_ack_i[1] = $urandom_range(0, 1);
      flush_i         = ($urandom_range(0, 59) == 0);
      #1;

      sz = mq.size();
      chk("rnd.ready", issue_ready_o, (sz < NE) && !flush_i);
      chk("rnd.empty", empty_o, sz == 0);
      chk("rnd.tid", issue_trans_id_o, m_next);
      for (int i = 0; i < NC; i++) begin
        ev[i] = (i < sz) ? mq[i].done : 1'b0;
        chk($sformatf("rnd.v%0d", i), commit_instr_o[i].valid, ev[i]);
        if (ev[i]) begin
          chk($sformatf("rnd.tid%0d", i), commit_instr_o[i].trans_id, mq[i].tid);
          chk($sformatf("rnd.res%0d", i), commit_instr_o[i].result, mq[i].result);
          chk($sformatf("rnd.pc%0d", i), commit_instr_o[i].pc, mq[i].pc);
          chk($sformatf("rnd.exv%0d", i), commit_instr_o[i].ex.valid, mq[i].exv);
          if (mq[i].exv)
            chk($sformatf("rnd.cause%0d", i), commit_instr_o[i].ex.cause, mq[i].cause);
        end
      end

      if (flush_i) begin
        mq.delete();
        m_next = 0;
      end else begin
        n = 0;
        if (commit_ack_i[0] && ev[0]) begin
          n = 1;
          if (commit_ack_i[1] && ev[1]) n = 2;
        end
        repeat (n) void'(mq.pop_front());
        for (int j = 0; j < mq.size(); j++) ox[j] = mq[j].exv;
        for (int k = 0; k < NW; k++) begin
          if (wb_valid_i[k]) begin
            for (int j = 0; j < mq.size(); j++) begin
              if (mq[j].tid == wb_trans_id_i[k]) begin
                mq[j].result = wb_result_i[k];
                mq[j].done   = 1'b1;
                if (wb_ex_i[k].valid && !ox[j]) begin
                  mq[j].exv   = 1'b1;
                  mq[j].cause = wb_ex_i[k].cause;
                end
              end
            end
          end
        end
        if (issue_valid_i && sz < NE) begin
          tmp.tid    = 4'(m_next);
          tmp.done   = issue_instr_i.ex.valid;
          tmp.result = issue_instr_i.result;
          tmp.pc     = issue_instr_i.pc;
          tmp.exv    = issue_instr_i.ex.valid;
          tmp.cause  = issue_instr_i.ex.cause;
          mq.push_back(tmp);
          m_next = (m_next + 1) % NE;
        end
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
